// File: rtl/apb_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// apb_irq_ctrl_pkg
// Shared definitions for the APB interrupt controller:
//   - byte offsets of the register map (only address bits [4:2] decoded)
//   - irq_id_t : 5-bit interrupt ID, value = source index + 1, 0 = none
//   - lowest_id(): lowest set bit of a vector converted to an ID
// ---------------------------------------------------------------------------
package apb_irq_ctrl_pkg;

    localparam logic [4:0] PENDING_OFF   = 5'h00;
    localparam logic [4:0] ENABLE_OFF    = 5'h04;
    localparam logic [4:0] TYPE_OFF      = 5'h08;
    localparam logic [4:0] CLAIM_OFF     = 5'h0C;
    localparam logic [4:0] INSERVICE_OFF = 5'h10;

    typedef logic [4:0] irq_id_t;

    // Scans from the top down so the lowest set bit is written last and wins.
    // A 5-bit ID can name at most 31 sources, so the vector is 31 bits wide.
    function automatic irq_id_t lowest_id(input logic [30:0] vec);
        irq_id_t id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (vec[i]) begin
                id = irq_id_t'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational fixed-priority encoder. The lowest eligible index wins.
// Ports:
//   eligible_i [NUM_SRC-1:0] : sources that are pending, enabled, not in service
//   win_id_o   [4:0]         : winning index + 1, or 0 when nothing is eligible
// ---------------------------------------------------------------------------
module irq_prio_enc
    import apb_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    output logic [4:0]         win_id_o
);

    logic [30:0] vec;

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        vec                = '0;
        vec[NUM_SRC-1:0]   = eligible_i;
    end

    assign win_id_o = lowest_id(vec);

endmodule

// File: rtl/apb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// apb_irq_ctrl
// APB slave interrupt controller. Collects NUM_SRC active-high interrupt
// lines, tracks enable / type / pending / in-service per source, and drives
// one registered CPU interrupt plus the ID of the winning source.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   psel_i .. pwdata_i    : APB request (only paddr_i[4:2] decoded)
//   prdata_o, pready_o,
//   pslverr_o             : APB response (zero wait states)
//   irq_src_i [NUM_SRC]   : interrupt lines, synchronous to clk
//   irq_o                 : registered interrupt request
//   irq_id_o  [4:0]       : registered winning ID (index + 1), 0 = none
// Register map: 0x00 PENDING (RO), 0x04 ENABLE, 0x08 TYPE (1 = rising edge),
//   0x0C CLAIM (read = claim, write = complete), 0x10 INSERVICE (RO).
// ---------------------------------------------------------------------------
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [NUM_SRC-1:0]    irq_src_i,
    output logic                  irq_o,
    output logic [4:0]            irq_id_o
);

    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] type_q, type_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] src_q, src_d;
    logic               irq_q, irq_d;
    irq_id_t            irq_id_q, irq_id_d;

    logic               access;
    logic [4:0]         reg_off;
    logic               off_valid;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] complete_vec;
    irq_id_t            win_id;
    logic [31:0]        rdata;
    logic               unused_bits;

    // Reset masks the access so a transfer caught by reset returns zero data
    // and no error while the state is being cleared.
    assign access  = psel_i & penable_i & ~reset;
    assign reg_off = {paddr_i[4:2], 2'b00};

    assign unused_bits = ^{paddr_i[ADDR_WIDTH-1:5], paddr_i[1:0], pwdata_i[31:NUM_SRC]};

    always_comb begin
        case (reg_off)
            PENDING_OFF, ENABLE_OFF, TYPE_OFF, CLAIM_OFF, INSERVICE_OFF: off_valid = 1'b1;
            default:                                                     off_valid = 1'b0;
        endcase
    end

    // Arbitration
    assign eligible = pending_q & enable_q & ~in_service_q;

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
        .eligible_i (eligible),
        .win_id_o   (win_id)
    );

    // Claim (read) and complete (write) decode as one-hot vectors. A complete
    // of an ID that is out of range or not in service matches nothing to clear.
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        if (access && off_valid && reg_off == CLAIM_OFF) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!pwrite_i) begin
                    claim_vec[i] = (win_id == irq_id_t'(i + 1));
                end else begin
                    complete_vec[i] = (pwdata_i[4:0] == irq_id_t'(i + 1));
                end
            end
        end
    end

    // Next state
    always_comb begin
        enable_d = enable_q;
        type_d   = type_q;
        if (access && pwrite_i) begin
            case (reg_off)
                ENABLE_OFF: enable_d = pwdata_i[NUM_SRC-1:0];
                TYPE_OFF:   type_d   = pwdata_i[NUM_SRC-1:0];
                default:    ;
            endcase
        end

        in_service_d = (in_service_q | claim_vec) & ~complete_vec;

        // Edge sources: a fresh edge wins over a same-cycle claim.
        // Level sources: pending simply tracks the line; claims do not clear it.
        // The current type_q is used, so a TYPE write takes effect next cycle.
        edge_det = irq_src_i & ~src_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (type_q[i]) begin
                pending_d[i] = edge_det[i] | (pending_q[i] & ~claim_vec[i]);
            end else begin
                pending_d[i] = irq_src_i[i];
            end
        end

        src_d    = irq_src_i;
        irq_d    = |eligible;
        irq_id_d = win_id;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q     <= '0;
            type_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            src_q        <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
        end else begin
            enable_q     <= enable_d;
            type_q       <= type_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            src_q        <= src_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
        end
    end

    // Read mux: live during the access phase only
    always_comb begin
        rdata = '0;
        if (access) begin
            case (reg_off)
                PENDING_OFF:   rdata[NUM_SRC-1:0] = pending_q;
                ENABLE_OFF:    rdata[NUM_SRC-1:0] = enable_q;
                TYPE_OFF:      rdata[NUM_SRC-1:0] = type_q;
                CLAIM_OFF:     rdata[4:0]         = win_id;
                INSERVICE_OFF: rdata[NUM_SRC-1:0] = in_service_q;
                default:       ;
            endcase
        end
    end

    assign prdata_o  = rdata;
    assign pready_o  = 1'b1;
    assign pslverr_o = access & ~off_valid;
    assign irq_o     = irq_q;
    assign irq_id_o  = irq_id_q;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_irq_ctrl
// Directed self-checking bench for apb_irq_ctrl (NUM_SRC = 8). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_apb_irq_ctrl;

    localparam logic [11:0] A_PEND  = 12'h000;
    localparam logic [11:0] A_EN    = 12'h004;
    localparam logic [11:0] A_TYPE  = 12'h008;
    localparam logic [11:0] A_CLAIM = 12'h00C;
    localparam logic [11:0] A_INSV  = 12'h010;
    localparam logic [11:0] A_BAD   = 12'h014;

    logic        clk;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  irq_src;
    logic        irq;
    logic [4:0]  irq_id;

    int checks   = 0;
    int failures = 0;

    apb_irq_ctrl #(.NUM_SRC(8), .ADDR_WIDTH(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .irq_src_i (irq_src),
        .irq_o     (irq),
        .irq_id_o  (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        d = prdata;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        #3;
        e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        check(tag, d, exp);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    task automatic wr_chk(input string tag, input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
        check({tag, "_err"}, 32'(e), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; irq_src = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_irq",    32'(irq),    32'd0);
        check("rst_id",     32'(irq_id), 32'd0);
        check("rst_pready", 32'(pready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        rd_chk("rst_pending", A_PEND,  32'h0);
        rd_chk("rst_enable",  A_EN,    32'h0);
        rd_chk("rst_type",    A_TYPE,  32'h0);
        rd_chk("rst_claim",   A_CLAIM, 32'h0);
        rd_chk("rst_insv",    A_INSV,  32'h0);
        apb_read(A_BAD, d, e);
        check("bad_off_err",  32'(e), 32'd1);
        check("bad_off_data", d,      32'h0);

        // ---------------- edge path ----------------
        wr_chk("edge_wr_en",   A_EN,   32'h05);
        wr_chk("edge_wr_type", A_TYPE, 32'h01);
        irq_src = 8'h01;
        @(posedge clk); #1;
        irq_src = 8'h00;
        check("edge_lat_irq1", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("edge_lat_irq2", 32'(irq),    32'd1);
        check("edge_lat_id2",  32'(irq_id), 32'd1);
        rd_chk("edge_pending", A_PEND,  32'h01);
        rd_chk("edge_claim",   A_CLAIM, 32'h1);
        rd_chk("edge_pend_after", A_PEND, 32'h0);
        rd_chk("edge_insv_after", A_INSV, 32'h01);
        check("edge_irq_after", 32'(irq),    32'd0);
        check("edge_id_after",  32'(irq_id), 32'd0);
        wr_chk("edge_complete", A_CLAIM, 32'd1);
        rd_chk("edge_insv_done", A_INSV, 32'h0);

        // ---------------- priority, level sources ----------------
        wr_chk("prio_wr_type", A_TYPE, 32'h00);
        wr_chk("prio_wr_en",   A_EN,   32'hFF);
        irq_src = 8'h0C;
        rd_chk("prio_claim3", A_CLAIM, 32'd3);
        rd_chk("prio_claim4", A_CLAIM, 32'd4);
        rd_chk("prio_claim0", A_CLAIM, 32'd0);
        rd_chk("prio_insv",   A_INSV,  32'h0C);
        rd_chk("prio_pend",   A_PEND,  32'h0C);
        wr_chk("prio_cmpl3",  A_CLAIM, 32'd3);
        rd_chk("prio_reclaim3", A_CLAIM, 32'd3);
        wr_chk("prio_cmpl3b", A_CLAIM, 32'd3);
        wr_chk("prio_cmpl4",  A_CLAIM, 32'd4);
        irq_src = 8'h00;
        rd_chk("prio_insv_clr", A_INSV, 32'h0);

        // ---------------- edge and claim in the same cycle ----------------
        wr_chk("sim_wr_type", A_TYPE, 32'h02);
        irq_src = 8'h02;
        @(posedge clk); #1;
        irq_src = 8'h00;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_CLAIM;
        @(posedge clk); #1;
        penable = 1'b1;
        irq_src = 8'h02;
        #3;
        check("sim_claim", prdata, 32'd2);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        irq_src = 8'h00;
        rd_chk("sim_pend", A_PEND, 32'h02);
        rd_chk("sim_insv", A_INSV, 32'h02);
        check("sim_irq_masked", 32'(irq), 32'd0);
        wr_chk("sim_cmpl2", A_CLAIM, 32'd2);
        @(posedge clk); #1;
        check("sim_irq_re", 32'(irq),    32'd1);
        check("sim_id_re",  32'(irq_id), 32'd2);
        rd_chk("sim_reclaim", A_CLAIM, 32'd2);
        wr_chk("sim_cmpl2b", A_CLAIM, 32'd2);

        // ---------------- bad completes, disable ----------------
        wr_chk("bad_wr_type", A_TYPE, 32'h00);
        irq_src = 8'h01;
        rd_chk("bad_claim1", A_CLAIM, 32'd1);
        wr_chk("bad_cmpl0", A_CLAIM, 32'd0);
        wr_chk("bad_cmpl9", A_CLAIM, 32'd9);
        wr_chk("bad_cmpl5", A_CLAIM, 32'd5);
        rd_chk("bad_insv", A_INSV, 32'h01);
        wr_chk("bad_cmpl1", A_CLAIM, 32'd1);
        @(posedge clk); #1;
        check("dis_irq_on", 32'(irq),    32'd1);
        check("dis_id_on",  32'(irq_id), 32'd1);
        wr_chk("dis_wr_en", A_EN, 32'hFE);
        check("dis_irq_hold", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check("dis_irq_off", 32'(irq),    32'd0);
        check("dis_id_off",  32'(irq_id), 32'd0);
        rd_chk("dis_pend", A_PEND, 32'h01);
        rd_chk("dis_insv", A_INSV, 32'h00);

        // ---------------- async reset mid-access ----------------
        wr_chk("ar_wr_en", A_EN, 32'hFF);
        irq_src = 8'h07;
        rd_chk("ar_claim1", A_CLAIM, 32'd1);
        rd_chk("ar_claim2", A_CLAIM, 32'd2);
        rd_chk("ar_insv",   A_INSV,  32'h03);
        check("ar_irq_pre", 32'(irq),    32'd1);
        check("ar_id_pre",  32'(irq_id), 32'd3);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_INSV;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("ar_data_pre", prdata, 32'h03);
        #1;
        reset = 1'b1;
        #1;
        check("ar_irq_async",    32'(irq),     32'd0);
        check("ar_id_async",     32'(irq_id),  32'd0);
        check("ar_data_async",   prdata,       32'h0);
        check("ar_pready_async", 32'(pready),  32'd1);
        check("ar_err_async",    32'(pslverr), 32'd0);
        irq_src = 8'h00;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        rd_chk("ar_pending", A_PEND, 32'h0);
        rd_chk("ar_enable",  A_EN,   32'h0);
        rd_chk("ar_type",    A_TYPE, 32'h0);
        rd_chk("ar_insv0",   A_INSV, 32'h0);
        check("ar_irq_post", 32'(irq), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
